// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage; load/store and stack push/pop over a req/ack data-memory port, owns SP.
// Latency: 1 cycle for non-memory ops; memory ops run IDLE -> ACCESS (1+ cycles) -> DONE, 3 cycles minimum.
// Backpressure: stall is high from op detection in IDLE through ACCESS; ACCESS waits on dmem_ack
// (or aborts after TIMEOUT cycles when MEM_TIMEOUT_EN is defined, which also adds the bus_err port).
module mem_access_stage #(
   parameter logic [7:0] SP_INIT = 8'hFF
`ifdef MEM_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 15
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_reg_write,
   input  logic       mem_mem_read,
   input  logic       mem_mem_write,
   input  logic [7:0] mem_alu_result,
   input  logic [7:0] mem_write_data,
   input  logic [1:0] mem_rd,
   input  logic [2:0] wb_result_mux_mem,
   input  logic       stack_push_mem,
   input  logic       stack_pop_mem,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic [7:0] dmem_addr,
   output logic [7:0] dmem_wdata,
   input  logic [7:0] dmem_rdata,
   input  logic       dmem_ack,
   output logic       stall,
   output logic [7:0] sp_value,
   output logic       stack_err,
   output logic       wb_reg_write,
   output logic [1:0] wb_rd,
   output logic [7:0] wb_alu_result,
   output logic [7:0] wb_mem_data,
   output logic [2:0] wb_result_mux
`ifdef MEM_TIMEOUT_EN
   ,
   output logic       bus_err
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t     state_q;
   logic [7:0] sp_q;
   logic       stack_err_q;

   // Memory port registers, held constant for the whole ACCESS phase
   logic       dmem_req_q;
   logic       dmem_we_q;
   logic [7:0] dmem_addr_q;
   logic [7:0] dmem_wdata_q;

   // Op controls captured in IDLE, replayed to writeback in DONE
   logic       lat_reg_write_q;
   logic [1:0] lat_rd_q;
   logic [7:0] lat_alu_q;
   logic [2:0] lat_mux_q;
   logic       lat_push_q;
   logic       lat_pop_q;
   logic [7:0] rdata_q;

   logic       wb_reg_write_q;
   logic [1:0] wb_rd_q;
   logic [7:0] wb_alu_result_q;
   logic [7:0] wb_mem_data_q;
   logic [2:0] wb_result_mux_q;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] tmo_cnt_q;
   logic             bus_err_q;
`endif

   logic       op;
   logic       acc_we_d;
   logic [7:0] acc_addr_d;

   assign op = mem_mem_read | mem_mem_write | stack_push_mem | stack_pop_mem;

   // Upstream freezes as soon as an op is seen and until the access completes
   assign stall = (state_q == ACCESS) || ((state_q == IDLE) && op);

   // Access selection by priority: push > pop > write > read
   always_comb begin
      acc_we_d   = 1'b0;
      acc_addr_d = mem_alu_result;
      if (stack_push_mem) begin
         acc_we_d   = 1'b1;
         acc_addr_d = sp_q;
      end else if (stack_pop_mem) begin
         acc_we_d   = 1'b0;
         acc_addr_d = sp_q + 8'd1;
      end else if (mem_mem_write) begin
         acc_we_d   = 1'b1;
      end
   end

   // Sequencer: op capture, memory handshake, SP update and registered MEM/WB bundle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         sp_q            <= SP_INIT;
         stack_err_q     <= 1'b0;
         dmem_req_q      <= 1'b0;
         dmem_we_q       <= 1'b0;
         dmem_addr_q     <= 8'h00;
         dmem_wdata_q    <= 8'h00;
         lat_reg_write_q <= 1'b0;
         lat_rd_q        <= 2'd0;
         lat_alu_q       <= 8'h00;
         lat_mux_q       <= 3'd0;
         lat_push_q      <= 1'b0;
         lat_pop_q       <= 1'b0;
         rdata_q         <= 8'h00;
         wb_reg_write_q  <= 1'b0;
         wb_rd_q         <= 2'd0;
         wb_alu_result_q <= 8'h00;
         wb_mem_data_q   <= 8'h00;
         wb_result_mux_q <= 3'd0;
`ifdef MEM_TIMEOUT_EN
         tmo_cnt_q       <= '0;
         bus_err_q       <= 1'b0;
`endif
      end else begin
         // Bubble by default; IDLE-without-op and DONE override below
         wb_reg_write_q  <= 1'b0;
         wb_rd_q         <= 2'd0;
         wb_alu_result_q <= 8'h00;
         wb_mem_data_q   <= 8'h00;
         wb_result_mux_q <= 3'd0;
         case (state_q)
            IDLE: begin
               if (op) begin
                  lat_reg_write_q <= mem_reg_write;
                  lat_rd_q        <= mem_rd;
                  lat_alu_q       <= mem_alu_result;
                  lat_mux_q       <= wb_result_mux_mem;
                  lat_push_q      <= stack_push_mem;
                  lat_pop_q       <= stack_pop_mem & ~stack_push_mem;
                  rdata_q         <= 8'h00;
`ifdef MEM_TIMEOUT_EN
                  tmo_cnt_q       <= '0;
`endif
                  if (stack_push_mem && stack_pop_mem) begin
                     // Contradictory stack request: flag it and skip the memory access
                     stack_err_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     dmem_req_q   <= 1'b1;
                     dmem_we_q    <= acc_we_d;
                     dmem_addr_q  <= acc_addr_d;
                     dmem_wdata_q <= mem_write_data;
                     state_q      <= ACCESS;
                  end
               end else begin
                  wb_reg_write_q  <= mem_reg_write;
                  wb_rd_q         <= mem_rd;
                  wb_alu_result_q <= mem_alu_result;
                  wb_result_mux_q <= wb_result_mux_mem;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  rdata_q    <= dmem_rdata;
                  dmem_req_q <= 1'b0;
                  state_q    <= DONE;
                  if (lat_push_q) begin
                     sp_q <= sp_q - 8'd1;
                     if (sp_q == 8'h00) stack_err_q <= 1'b1;
                  end else if (lat_pop_q) begin
                     sp_q <= sp_q + 8'd1;
                     if (sp_q == 8'hFF) stack_err_q <= 1'b1;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Abort: no data, SP untouched
                  rdata_q    <= 8'h00;
                  dmem_req_q <= 1'b0;
                  bus_err_q  <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
               end
`endif
            end
            DONE: begin
               wb_reg_write_q  <= lat_reg_write_q;
               wb_rd_q         <= lat_rd_q;
               wb_alu_result_q <= lat_alu_q;
               wb_mem_data_q   <= rdata_q;
               wb_result_mux_q <= lat_mux_q;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req      = dmem_req_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign sp_value      = sp_q;
   assign stack_err     = stack_err_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign wb_rd         = wb_rd_q;
   assign wb_alu_result = wb_alu_result_q;
   assign wb_mem_data   = wb_mem_data_q;
   assign wb_result_mux = wb_result_mux_q;
`ifdef MEM_TIMEOUT_EN
   assign bus_err       = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: transaction-level model of SP, memory and the writeback bundle,
// randomized instruction stream with random ack delays, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mem_access_stage;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_reg_write, mem_mem_read, mem_mem_write;
   logic [7:0] mem_alu_result, mem_write_data;
   logic [1:0] mem_rd;
   logic [2:0] wb_result_mux_mem;
   logic       stack_push_mem, stack_pop_mem;
   logic       dmem_req, dmem_we;
   logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic       dmem_ack;
   logic       stall;
   logic [7:0] sp_value;
   logic       stack_err;
   logic       wb_reg_write;
   logic [1:0] wb_rd;
   logic [7:0] wb_alu_result, wb_mem_data;
   logic [2:0] wb_result_mux;
`ifdef MEM_TIMEOUT_EN
   logic       bus_err;
`endif

   always #5 clk = ~clk;

   mem_access_stage #(
      .SP_INIT(8'hFF)
`ifdef MEM_TIMEOUT_EN
      , .TIMEOUT(TMO)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data), .mem_rd(mem_rd),
      .wb_result_mux_mem(wb_result_mux_mem), .stack_push_mem(stack_push_mem), .stack_pop_mem(stack_pop_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .sp_value(sp_value),
      .stack_err(stack_err), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
      .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_result_mux(wb_result_mux)
`ifdef MEM_TIMEOUT_EN
      , .bus_err(bus_err)
`endif
   );

   int checks = 0;
   int errors = 0;
   int stall_cnt = 0;
   int req_cnt = 0;
   logic [7:0] last_addr;
   logic       last_we;

   // Reference model state
   logic [7:0] mem_m [256];
   logic [7:0] sp_m;
   bit         err_m;
   bit         berr_m;
   // Writeback bundle the model expects to appear next
   bit         p_vld, p_rw, p_mchk;
   logic [1:0] p_rd;
   logic [7:0] p_alu, p_mdat;
   logic [2:0] p_mux;

   // Expectations for the current cycle
   bit         e_en, e_stall, e_req, e_dm, e_we, e_err, e_berr, e_wbchk, e_mchk, e_bub, e_rw;
   logic [7:0] e_addr, e_wdata, e_sp, e_alu, e_mdat;
   logic [1:0] e_rd;
   logic [2:0] e_mux;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: DUT against the model, mid-cycle
   always @(negedge clk) begin
      if (stall === 1'b1) stall_cnt++;
      if (dmem_req === 1'b1) begin
         req_cnt++;
         last_addr = dmem_addr;
         last_we   = dmem_we;
      end
      if (e_en) begin
         chk("stall", stall, e_stall);
         chk("dmem_req", dmem_req, e_req);
         chk("sp_value", sp_value, e_sp);
         chk("stack_err", stack_err, e_err);
`ifdef MEM_TIMEOUT_EN
         chk("bus_err", bus_err, e_berr);
`endif
         if (e_dm) begin
            chk("dmem_addr", dmem_addr, e_addr);
            chk("dmem_we", dmem_we, e_we);
            if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
         end
         if (e_wbchk) begin
            chk("wb_reg_write", wb_reg_write, e_rw);
            chk("wb_rd", wb_rd, e_rd);
            chk("wb_alu_result", wb_alu_result, e_alu);
            chk("wb_result_mux", wb_result_mux, e_mux);
            if (e_mchk) chk("wb_mem_data", wb_mem_data, e_mdat);
         end
         if (e_bub) chk("wb_bubble", wb_reg_write, 1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_model();
      sp_m = 8'hFF; err_m = 0; berr_m = 0;
      p_vld = 1; p_rw = 0; p_rd = 0; p_alu = 0; p_mux = 0; p_mdat = 0; p_mchk = 1;
   endtask

   task automatic zero_inputs();
      mem_reg_write = 0; mem_mem_read = 0; mem_mem_write = 0; mem_alu_result = 0;
      mem_write_data = 0; mem_rd = 0; wb_result_mux_mem = 0; stack_push_mem = 0;
      stack_pop_mem = 0; dmem_ack = 0; dmem_rdata = 0;
   endtask

   task automatic do_reset(input int n);
      e_en = 0;
      rst = 1;
      zero_inputs();
      repeat (n) step();
      rst = 0;
      reset_model();
   endtask

   // One instruction from EX/MEM; dly = ACCESS cycles before the ack cycle, negative = never ack
   task automatic run_instr(input bit rw, input bit mr, input bit mw, input bit pu, input bit po,
                            input logic [7:0] alu, input logic [7:0] wd, input logic [1:0] rd,
                            input logic [2:0] mux, input int dly, input bit force_ack);
      bit         op, we;
      logic [7:0] a, rdat;
      mem_reg_write = rw; mem_mem_read = mr; mem_mem_write = mw; stack_push_mem = pu;
      stack_pop_mem = po; mem_alu_result = alu; mem_write_data = wd; mem_rd = rd;
      wb_result_mux_mem = mux; dmem_ack = 0;
      op = mr | mw | pu | po;
      e_en = 1; e_sp = sp_m; e_err = err_m; e_berr = berr_m; e_req = 0; e_dm = 0; e_stall = op;
      e_wbchk = p_vld; e_rw = p_rw; e_rd = p_rd; e_alu = p_alu; e_mux = p_mux;
      e_mdat = p_mdat; e_mchk = p_mchk; e_bub = 0;
      rdat = 8'h00;
      if (!op) begin
         if (force_ack || $urandom_range(3) == 0) begin
            dmem_ack = 1; dmem_rdata = 8'($urandom);
         end
         p_vld = 1; p_rw = rw; p_rd = rd; p_alu = alu; p_mux = mux; p_mchk = 0; p_mdat = 0;
         step();
         dmem_ack = 0;
         return;
      end
      step();
      e_wbchk = 0; e_bub = 1;
      if (pu && po) begin
         err_m = 1; p_mdat = 0; p_mchk = 0;
      end else begin
         if (pu) begin a = sp_m; we = 1; end
         else if (po) begin a = sp_m + 8'd1; we = 0; end
         else begin a = alu; we = mw; end
         e_req = 1; e_dm = 1; e_addr = a; e_we = we; e_wdata = wd;
         if (dly >= 0) begin
            for (int i = 0; i <= dly; i++) begin
               if (i == dly) begin
                  rdat = we ? 8'($urandom) : mem_m[a];
                  dmem_ack = 1; dmem_rdata = rdat;
               end else begin
                  dmem_ack = 0; dmem_rdata = 8'($urandom);
               end
               step();
            end
            if (we) mem_m[a] = wd;
            if (pu) begin
               if (sp_m == 8'h00) err_m = 1;
               sp_m = sp_m - 8'd1;
            end else if (po) begin
               if (sp_m == 8'hFF) err_m = 1;
               sp_m = sp_m + 8'd1;
            end
            p_mdat = rdat; p_mchk = !we;
         end
`ifdef MEM_TIMEOUT_EN
         else begin
            for (int i = 0; i < TMO; i++) begin
               dmem_ack = 0; dmem_rdata = 8'($urandom);
               step();
            end
            berr_m = 1; p_mdat = 8'h00; p_mchk = 1;
         end
`endif
      end
      // DONE cycle: a stray ack here must be ignored
      e_stall = 0; e_req = 0; e_dm = 0; e_sp = sp_m; e_err = err_m; e_berr = berr_m;
      dmem_ack = ($urandom_range(3) == 0); dmem_rdata = 8'($urandom);
      p_vld = 1; p_rw = rw; p_rd = rd; p_alu = alu; p_mux = mux;
      step();
      dmem_ack = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] sp_save;
      e_en = 0;
      rst = 1;
      zero_inputs();
      for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
      do_reset(2);

      // Reset state and a plain ALU op
      chk("rst_sp", sp_value, 8'hFF);
      chk("rst_stall", stall, 1'b0);
      chk("rst_wb_reg_write", wb_reg_write, 1'b0);
      chk("rst_stack_err", stack_err, 1'b0);
      run_instr(1, 0, 0, 0, 0, 8'h5A, 8'h00, 2'd2, 3'd1, 0, 1);
      chk("t1_wb_rd", wb_rd, 2'd2);
      chk("t1_wb_alu", wb_alu_result, 8'h5A);
      chk("t1_stall", stall, 1'b0);

      // Push 0x33 with one wait cycle, then pop it back
      stall_cnt = 0;
      run_instr(1, 0, 0, 1, 0, 8'h00, 8'h33, 2'd1, 3'd2, 1, 0);
      chk("t2_push_stall_cycles", stall_cnt, 3);
      chk("t2_push_addr", last_addr, 8'hFF);
      chk("t2_push_we", last_we, 1'b1);
      chk("t2_push_sp", sp_value, 8'hFE);
      run_instr(1, 0, 0, 0, 1, 8'h00, 8'h00, 2'd3, 3'd4, 0, 0);
      chk("t2_pop_addr", last_addr, 8'hFF);
      chk("t2_pop_sp", sp_value, 8'hFF);
      chk("t2_pop_data", wb_mem_data, 8'h33);

      // Load with immediate ack
      mem_m[8'h10] = 8'hC4;
      stall_cnt = 0;
      run_instr(1, 1, 0, 0, 0, 8'h10, 8'h00, 2'd1, 3'd3, 0, 0);
      chk("t3_stall_cycles", stall_cnt, 2);
      chk("t3_addr", last_addr, 8'h10);
      chk("t3_data", wb_mem_data, 8'hC4);
      chk("t3_wb_reg_write", wb_reg_write, 1'b1);

      // Drain the stack to 0x00, overflow, push+pop conflict, underflow
      for (int i = 0; i < 255; i++)
         run_instr(0, 0, 0, 1, 0, 8'h00, 8'(i), 2'd0, 3'd0, $urandom_range(1), 0);
      chk("t4_sp_bottom", sp_value, 8'h00);
      chk("t4_no_err_yet", stack_err, 1'b0);
      run_instr(0, 0, 0, 1, 0, 8'h00, 8'hAB, 2'd0, 3'd0, 0, 0);
      chk("t4_overflow_sp", sp_value, 8'hFF);
      chk("t4_overflow_err", stack_err, 1'b1);
      req_cnt = 0;
      run_instr(1, 0, 0, 1, 1, 8'h00, 8'h00, 2'd1, 3'd1, 0, 0);
      chk("t4_conflict_req_cycles", req_cnt, 0);
      chk("t4_conflict_sp", sp_value, 8'hFF);
      run_instr(1, 0, 0, 0, 1, 8'h00, 8'h00, 2'd2, 3'd2, 0, 0);
      chk("t4_underflow_addr", last_addr, 8'h00);
      chk("t4_underflow_sp", sp_value, 8'h00);

      // Reset during ACCESS followed by a late ack
      e_en = 0;
      mem_mem_read = 1; mem_alu_result = 8'h20; mem_reg_write = 1;
      step();
      chk("t5_req_in_access", dmem_req, 1'b1);
      rst = 1;
      step();
      rst = 0;
      zero_inputs();
      dmem_ack = 1; dmem_rdata = 8'h99;
      chk("t5_req_dropped", dmem_req, 1'b0);
      chk("t5_sp_init", sp_value, 8'hFF);
      chk("t5_err_cleared", stack_err, 1'b0);
      chk("t5_wb_reg_write", wb_reg_write, 1'b0);
      step();
      dmem_ack = 0;
      chk("t5_no_wb_update", wb_reg_write, 1'b0);
      chk("t5_stall_idle", stall, 1'b0);
      reset_model();

`ifdef MEM_TIMEOUT_EN
      // Never-acked push aborts after TMO ACCESS cycles
      sp_save = sp_m;
      run_instr(1, 0, 0, 1, 0, 8'h00, 8'h77, 2'd1, 3'd5, -1, 0);
      chk("t6_bus_err", bus_err, 1'b1);
      chk("t6_mem_data", wb_mem_data, 8'h00);
      chk("t6_sp_unchanged", sp_value, sp_save);
`else
      sp_save = sp_m;
`endif

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         int  kind;
         bit  mr, mw, pu, po;
         kind = $urandom_range(7);
         mr = 0; mw = 0; pu = 0; po = 0;
         case (kind)
            3: mr = 1;
            4: mw = 1;
            5: pu = 1;
            6: po = 1;
            7: begin
               mr = 1'($urandom); mw = 1'($urandom); pu = 1'($urandom); po = 1'($urandom);
            end
            default: ;
         endcase
         if ($urandom_range(49) == 0) do_reset(1);
         run_instr(1'($urandom), mr, mw, pu, po, 8'($urandom), 8'($urandom), 2'($urandom),
                   3'($urandom), $urandom_range(3), 0);
      end
      run_instr(0, 0, 0, 0, 0, 8'h00, 8'h00, 2'd0, 3'd0, 0, 0);
      e_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Pipeline MEM stage, directly downstream of the EX/MEM register. Consumes its control and data outputs and performs the data-memory load/store or stack push/pop over a req/ack memory handshake. Owns the stack pointer and stalls upstream stages while a memory transaction is outstanding. Drives a registered MEM/WB bundle to writeback.

Parameters:
SP_INIT, 8'hFF, stack pointer reset value
TIMEOUT, 15, maximum ACCESS cycles without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_reg_write  in  1  writeback enable from EX/MEM
mem_mem_read  in  1  load request
mem_mem_write  in  1  store request
mem_alu_result  in  8  load/store address, or ALU result for writeback
mem_write_data  in  8  store/push data
mem_rd  in  2  destination register
wb_result_mux_mem  in  3  writeback source select, passed through
stack_push_mem  in  1  push request
stack_pop_mem  in  1  pop request
dmem_req  out  1  memory request
dmem_we  out  1  memory write enable
dmem_addr  out  8  memory address
dmem_wdata  out  8  memory write data
dmem_rdata  in  8  memory read data
dmem_ack  in  1  memory completion, one cycle
stall  out  1  freeze upstream pipeline registers
sp_value  out  8  current stack pointer
stack_err  out  1  sticky stack fault
wb_reg_write  out  1  registered writeback enable
wb_rd  out  2  registered destination
wb_alu_result  out  8  registered ALU result
wb_mem_data  out  8  registered load/pop data
wb_result_mux  out  3  registered writeback select

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; sp_value=SP_INIT; all wb_* outputs=0; dmem_req=0; stack_err=0.
- Reset mid-transaction: return to IDLE. dmem_req drops after that edge, and any late ack is ignored.
- Memory op ("op") = mem_mem_read | mem_mem_write | stack_push_mem | stack_pop_mem.
- State IDLE, no op: at the next edge the wb_* bundle loads the inputs. Latency is 1 cycle. stall=0.
- State IDLE, op present: stall=1 (combinational). Inputs are latched internally. Next state is ACCESS. The wb bundle loads a bubble (wb_reg_write=0).
- State ACCESS: dmem_req=1 and stall=1. The wb bundle keeps loading bubbles.
  - On dmem_ack: capture dmem_rdata, update SP, go to DONE.
  - dmem_ack seen in IDLE or DONE is ignored.
- State DONE: stall=0. The wb bundle loads the latched controls, with wb_mem_data = captured data. Next state is IDLE.
- Memory-op latency: minimum 3 cycles (ack in the first ACCESS cycle).
- Priority among requests: push > pop > write > read. Only one access is performed per op.
- Push: dmem_we=1, dmem_addr=SP, dmem_wdata=mem_write_data. On ack, SP <= SP-1 (post-decrement).
- Pop: dmem_we=0, dmem_addr=SP+1. On ack, SP <= SP+1 (pre-increment).
- Load/store: dmem_addr=mem_alu_result. Store drives dmem_wdata=mem_write_data, dmem_we=1.
- Overflow: push at SP=8'h00 wraps SP to 8'hFF and sets stack_err.
- Underflow: pop at SP=8'hFF reads address 8'h00, wraps SP to 8'h00, and sets stack_err.
- Push and pop asserted together: no memory access, SP unchanged, stack_err set. Sequence still runs IDLE→DONE in 2 cycles, with dmem_req never asserted.
- stack_err is cleared only by rst.
- dmem_addr, dmem_we and dmem_wdata are held stable for the whole of ACCESS.

Optional Feature:
MEM_TIMEOUT_EN. When defined:
- A counter runs in ACCESS. After TIMEOUT cycles without ack, the request is aborted and the block goes to DONE.
- On abort: wb_mem_data=8'h00, SP unchanged, and sticky output bus_err (1 bit, reset 0) is set.
When undefined: no counter, no bus_err port, and ACCESS waits indefinitely.

Test Plan:
1. After rst: sp_value=8'hFF, wb_reg_write=0, stall=0. Then ALU op (reg_write=1, rd=2, alu=8'h5A, no op) → next cycle wb_rd=2, wb_alu_result=8'h5A, stall=0.
2. Push with data 8'h33, ack after 2 ACCESS cycles → dmem_addr=8'hFF, dmem_we=1, stall high for 3 cycles, sp_value=8'hFE. Then pop with rdata=8'h33 → dmem_addr=8'hFF, sp_value=8'hFF, wb_mem_data=8'h33.
3. Load at address 8'h10, rdata=8'hC4, ack immediate → exactly 3-cycle sequence; wb_mem_data=8'hC4; wb_reg_write=0 during stall cycles.
4. Force SP to 8'h00 via 255 pushes, then push once more → sp_value=8'hFF, stack_err=1. Push and pop together → no dmem_req, SP unchanged.
5. rst asserted during ACCESS, then ack → state IDLE, dmem_req=0, sp_value=SP_INIT, no wb update.
6. With MEM_TIMEOUT_EN, TIMEOUT=15, no ack → abort after 15 ACCESS cycles, bus_err=1, wb_mem_data=8'h00.
